// File: rtl/sensor_crop_ctrl.sv
// Frame-synchronous crop window controller: shadow/active window registers, pixel/line
// tracking and a registered crop gate aligned with 1-cycle-delayed pixel data.
module sensor_crop_ctrl #(
    parameter int IMAGE_HSIZE_SOURCE = 1280,
    parameter int IMAGE_VSIZE_SOURCE = 1024,
    parameter int IMAGE_HSIZE_TARGET = 1280,
    parameter int IMAGE_VSIZE_TARGET = 960
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [11:0] cfg_wdata,
    input  logic        image_in_vsync,
    input  logic        image_in_href,
    output logic        win_vsync,
    output logic        win_href,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        cfg_pending,
    output logic        cfg_err
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, FRAME} state_t;

    typedef struct packed {
        logic [11:0] xstart;
        logic [11:0] ystart;
        logic [11:0] width;
        logic [11:0] height;
    } win_t;

    localparam win_t DEF_WIN = '{
        xstart: 12'((IMAGE_HSIZE_SOURCE - IMAGE_HSIZE_TARGET) / 2),
        ystart: 12'((IMAGE_VSIZE_SOURCE - IMAGE_VSIZE_TARGET) / 2),
        width:  12'(IMAGE_HSIZE_TARGET),
        height: 12'(IMAGE_VSIZE_TARGET)
    };
    localparam logic [12:0] HS = 13'(IMAGE_HSIZE_SOURCE);
    localparam logic [12:0] VS = 13'(IMAGE_VSIZE_SOURCE);

    state_t      state;
    win_t        shadow;
    win_t        active;
    logic        enable_req;
    logic        vsync_r;
    logic        href_r;
    logic [11:0] xpos;
    logic [11:0] ypos;

    logic        sof;
    logic        eof;
    logic        wr_ctrl;
    logic        commit_wr;
    logic        cfg_valid;
    logic        in_win;
    logic [12:0] sh_xend;
    logic [12:0] sh_yend;
    logic [12:0] ac_xend;
    logic [12:0] ac_yend;

    assign sof       = image_in_vsync && !vsync_r;
    assign eof       = !image_in_vsync && vsync_r;
    assign wr_ctrl   = cfg_we && (cfg_addr == 3'd0);
    assign commit_wr = wr_ctrl && cfg_wdata[1];

    // 13-bit sums so a window running past 4095 is rejected instead of wrapping.
    assign sh_xend   = {1'b0, shadow.xstart} + {1'b0, shadow.width};
    assign sh_yend   = {1'b0, shadow.ystart} + {1'b0, shadow.height};
    assign cfg_valid = (shadow.width != 12'd0) && (shadow.height != 12'd0) &&
                       (sh_xend <= HS) && (sh_yend <= VS);

    assign ac_xend = {1'b0, active.xstart} + {1'b0, active.width};
    assign ac_yend = {1'b0, active.ystart} + {1'b0, active.height};
    assign in_win  = (xpos >= active.xstart) && ({1'b0, xpos} < ac_xend) &&
                     (ypos >= active.ystart) && ({1'b0, ypos} < ac_yend);

    assign win_vsync = vsync_r;

    // Configuration: shadow writes, commit request and frame-start hand-over.
    // NOTE: the window registers are a handful of flops, not a RAM, so they take the
    // default window on reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= DEF_WIN;
            active      <= DEF_WIN;
            enable_req  <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so the SOF check below sees the
            // shadow/pending values from before any write in this same cycle.
            cfg_err <= sof && cfg_pending && !cfg_valid;
            if (sof && cfg_pending && cfg_valid)
                active <= shadow;
            if (commit_wr)
                cfg_pending <= 1'b1;
            else if (sof)
                cfg_pending <= 1'b0;
            if (wr_ctrl)
                enable_req <= cfg_wdata[0];
            if (cfg_we) begin
                case (cfg_addr)
                    3'd1:    shadow.xstart <= cfg_wdata;
                    3'd2:    shadow.ystart <= cfg_wdata;
                    3'd3:    shadow.width  <= cfg_wdata;
                    3'd4:    shadow.height <= cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Pixel and line position, both saturating at 4095.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            xpos    <= 12'd0;
            ypos    <= 12'd0;
        end else begin
            vsync_r <= image_in_vsync;
            href_r  <= image_in_href;
            if (!image_in_href)
                xpos <= 12'd0;
            else if (xpos != 12'hFFF)
                xpos <= xpos + 12'd1;
            if (!image_in_vsync)
                ypos <= 12'd0;
            else if (href_r && !image_in_href && ypos != 12'hFFF)
                ypos <= ypos + 12'd1;
        end
    end

    // Enable sequencing; only whole frames between SOF and EOF are gated and counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            win_href   <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            win_href   <= (state == FRAME) && image_in_href && in_win;
            case (state)
                IDLE:     if (enable_req) state <= WAIT_SOF;
                WAIT_SOF: begin
                    if (!enable_req)
                        state <= IDLE;
                    else if (sof)
                        state <= FRAME;
                end
                FRAME: begin
                    if (eof) begin
                        state      <= enable_req ? WAIT_SOF : IDLE;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                    end
                end
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_crop_ctrl.sv
// Directed bench for sensor_crop_ctrl on a reduced 64x40 sensor (default window 48x24
// centred at x=8, y=8); a table of commit vectors plus hand-written corner sequences.
module tb_sensor_crop_ctrl;

    localparam int FW = 64;
    localparam int FH = 40;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic        image_in_vsync;
    logic        image_in_href;
    logic        win_vsync;
    logic        win_href;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        cfg_pending;
    logic        cfg_err;

    sensor_crop_ctrl #(
        .IMAGE_HSIZE_SOURCE(64),
        .IMAGE_VSIZE_SOURCE(40),
        .IMAGE_HSIZE_TARGET(48),
        .IMAGE_VSIZE_TARGET(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .image_in_vsync(image_in_vsync),
        .image_in_href(image_in_href),
        .win_vsync(win_vsync),
        .win_href(win_href),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt),
        .cfg_pending(cfg_pending),
        .cfg_err(cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int err;
        int cnt;
        int pxmin;
        int pxmax;
        int lnmin;
        int lnmax;
    } vec_t;

    vec_t vecs[5];

    int n_checks = 0;
    int n_errors = 0;
    int exp_frames = 0;

    int cur_px;
    int cur_line;
    int st_cnt;
    int st_pxmin;
    int st_pxmax;
    int st_lnmin;
    int st_lnmax;
    int st_done;
    int st_err;

    int mid_line = -1;
    int mid_n = 0;
    int mid_addr[5];
    int mid_data[5];
    bit sof_commit = 1'b0;
    int rst_line = -1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock; outputs are sampled 1 ns after the edge and tallied against the
    // pixel/line that was on the inputs at that edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (win_href === 1'b1) begin
            st_cnt++;
            if (cur_px < st_pxmin) st_pxmin = cur_px;
            if (cur_px > st_pxmax) st_pxmax = cur_px;
            if (cur_line < st_lnmin) st_lnmin = cur_line;
            if (cur_line > st_lnmax) st_lnmax = cur_line;
        end
        if (frame_done === 1'b1) st_done++;
        if (cfg_err === 1'b1) st_err++;
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(addr);
        cfg_wdata = 12'(data);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic wr_window(input int x, input int y, input int w, input int h);
        wr(1, x);
        wr(2, y);
        wr(3, w);
        wr(4, h);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_win_vsync"}, win_vsync, 0);
        check({tag, "_win_href"}, win_href, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_cfg_pending"}, cfg_pending, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    task automatic run_frame(input int nlines, input int hlen);
        st_cnt = 0; st_done = 0; st_err = 0;
        st_pxmin = 1000000; st_pxmax = -1;
        st_lnmin = 1000000; st_lnmax = -1;
        cur_px = -1; cur_line = -1;
        image_in_vsync = 1'b0;
        image_in_href  = 1'b0;
        repeat (4) tick();
        image_in_vsync = 1'b1;
        if (sof_commit) begin
            cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 12'd3;
        end
        tick();
        cfg_we = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < hlen; p++) begin
                image_in_href = 1'b1;
                cur_px = p;
                cur_line = l;
                if (l == mid_line && p < mid_n) begin
                    cfg_we = 1'b1; cfg_addr = 3'(mid_addr[p]); cfg_wdata = 12'(mid_data[p]);
                end else begin
                    cfg_we = 1'b0;
                end
                if (l == rst_line && p == 16) begin
                    check("pre_reset_win_href", win_href, 1);
                    check("pre_reset_win_vsync", win_vsync, 1);
                    rst_n = 1'b0;
                    #1;
                    check_outputs_zero("reset_mid_frame");
                end
                tick();
                if (l == rst_line && p == 20) rst_n = 1'b1;
            end
            image_in_href = 1'b0;
            cfg_we = 1'b0;
            cur_px = -1;
            cur_line = -1;
            repeat (4) tick();
        end
        image_in_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_frame(input string tag, input int cnt, input int pxmin, input int pxmax,
                               input int lnmin, input int lnmax, input int done, input int err);
        check({tag, "_gated"}, st_cnt, cnt);
        if (cnt > 0) begin
            check({tag, "_px_min"}, st_pxmin, pxmin);
            check({tag, "_px_max"}, st_pxmax, pxmax);
            check({tag, "_line_min"}, st_lnmin, lnmin);
            check({tag, "_line_max"}, st_lnmax, lnmax);
        end
        check({tag, "_frame_done"}, st_done, done);
        check({tag, "_cfg_err"}, st_err, err);
        check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    endtask

    initial begin
        // Window vectors on the 64x40 sensor; rejected entries keep the T0 window.
        vecs[0] = '{44, 0, 20, 40, 0, 800, 44, 63, 0, 39};  // exactly fills right/bottom edge
        vecs[1] = '{50, 5, 20, 4, 1, 800, 44, 63, 0, 39};   // x end 70 > 64
        vecs[2] = '{0, 10, 0, 4, 1, 800, 44, 63, 0, 39};    // zero width
        vecs[3] = '{0, 37, 8, 4, 1, 800, 44, 63, 0, 39};    // y end 41 > 40
        vecs[4] = '{3, 36, 7, 4, 0, 28, 3, 9, 36, 39};

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 12'd0;
        image_in_vsync = 1'b0; image_in_href = 1'b0;
        cur_px = -1; cur_line = -1;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // Default centred window.
        wr(0, 1);
        run_frame(FH, FW);
        exp_frames = 1;
        check_frame("default", 1152, 8, 55, 8, 31, 1, 0);

        // Commit mid-frame: old window this frame, new window next frame.
        mid_line = 1; mid_n = 5;
        mid_addr = '{1, 2, 3, 4, 0};
        mid_data = '{10, 5, 20, 4, 3};
        run_frame(FH, FW);
        mid_line = -1;
        exp_frames = 2;
        check_frame("midcommit_old", 1152, 8, 55, 8, 31, 1, 0);
        check("midcommit_pending_held", cfg_pending, 1);
        run_frame(FH, FW);
        exp_frames = 3;
        check_frame("midcommit_new", 80, 10, 29, 5, 8, 1, 0);
        check("midcommit_pending_clear", cfg_pending, 0);

        // Table: write window + commit between frames, then one frame.
        for (int i = 0; i < 5; i++) begin
            wr_window(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h);
            wr(0, 3);
            check($sformatf("vec%0d_pending_set", i), cfg_pending, 1);
            run_frame(FH, FW);
            exp_frames++;
            check_frame($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].pxmin, vecs[i].pxmax,
                        vecs[i].lnmin, vecs[i].lnmax, 1, vecs[i].err);
            check($sformatf("vec%0d_pending_clear", i), cfg_pending, 0);
        end

        // Commit coincident with SOF: deferred by one frame.
        wr_window(0, 0, 4, 2);
        sof_commit = 1'b1;
        run_frame(FH, FW);
        sof_commit = 1'b0;
        exp_frames++;
        check_frame("sofcommit_old", 28, 3, 9, 36, 39, 1, 0);
        check("sofcommit_pending_held", cfg_pending, 1);
        run_frame(FH, FW);
        exp_frames++;
        check_frame("sofcommit_new", 8, 0, 3, 0, 1, 1, 0);
        check("sofcommit_pending_clear", cfg_pending, 0);

        // Lines longer than 4096 cycles: xpos saturates, no second gate burst.
        run_frame(2, 4200);
        exp_frames++;
        check_frame("longline", 8, 0, 3, 0, 1, 1, 0);

        // Disable mid-frame: this frame completes, the next is not gated.
        mid_line = 1; mid_n = 1;
        mid_addr[0] = 0; mid_data[0] = 0;
        run_frame(FH, FW);
        mid_line = -1;
        exp_frames++;
        check_frame("disable_mid", 8, 0, 3, 0, 1, 1, 0);

        // Commit without enable: SOF in IDLE still applies it.
        wr_window(10, 5, 20, 4);
        wr(0, 2);
        check("idle_pending_set", cfg_pending, 1);
        run_frame(FH, FW);
        check_frame("idle_frame", 0, 0, 0, 0, 0, 0, 0);
        check("idle_pending_clear", cfg_pending, 0);

        // Enable mid-frame: nothing until the next SOF.
        mid_line = 1; mid_n = 1;
        mid_addr[0] = 0; mid_data[0] = 1;
        run_frame(FH, FW);
        mid_line = -1;
        check_frame("enable_mid", 0, 0, 0, 0, 0, 0, 0);
        run_frame(FH, FW);
        exp_frames++;
        check_frame("enable_next", 80, 10, 29, 5, 8, 1, 0);

        // Async reset during an active frame.
        rst_line = 6;
        run_frame(FH, FW);
        rst_line = -1;
        exp_frames = 0;
        check_frame("reset_frame", 26, 10, 29, 5, 6, 0, 0);
        run_frame(FH, FW);
        check_frame("after_reset_no_enable", 0, 0, 0, 0, 0, 0, 0);
        wr(0, 1);
        run_frame(FH, FW);
        exp_frames = 1;
        check_frame("after_reset_enabled", 1152, 8, 55, 8, 31, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
